// File: rtl/add64_seq_ctrl.sv
// 64-bit add/subtract unit that reuses one 16-bit carry-lookahead slice over
// four cycles (low slice first), with valid/ready request and result ports.
module add64_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic        sub,
  input  logic        cin,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds its payload stable until that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  slice_q;
  logic        carry_q;
  logic [63:0] a_q, b_q;
  logic [63:0] sum_q;
  logic        cout_q, ovf_q;

  // 4-bit lookahead: returns carries into positions 0..4 (bit 0 is ci).
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [15:0] op_a, op_b, sl_g, sl_p, sl_s;
  logic [16:0] sl_c;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  grp_c;
  logic [4:0]  bit_c;

  // Slice adder: bit g/p, group g/p, second-level lookahead for group carries.
  always_comb begin
    op_a  = a_q[{slice_q, 4'b0000} +: 16];
    op_b  = b_q[{slice_q, 4'b0000} +: 16];
    sl_g  = op_a & op_b;
    sl_p  = op_a ^ op_b;
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < 4; j++) begin
      grp_g[j] = sl_g[4*j+3] | (sl_p[4*j+3] & sl_g[4*j+2])
               | (sl_p[4*j+3] & sl_p[4*j+2] & sl_g[4*j+1])
               | (sl_p[4*j+3] & sl_p[4*j+2] & sl_p[4*j+1] & sl_g[4*j]);
      grp_p[j] = &sl_p[4*j +: 4];
    end
    grp_c = cla4(grp_g, grp_p, carry_q);
    sl_c  = '0;
    bit_c = '0;
    for (int j = 0; j < 4; j++) begin
      bit_c         = cla4(sl_g[4*j +: 4], sl_p[4*j +: 4], grp_c[j]);
      sl_c[4*j +: 5] = bit_c;
    end
    sl_c[16] = grp_c[4];
    sl_s     = sl_p ^ sl_c[15:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (slice_q == 2'd3) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_q <= 2'd0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            slice_q <= 2'd0;
          end
        end
        RUN: begin
          sum_q[{slice_q, 4'b0000} +: 16] <= sl_s;
          carry_q <= sl_c[16];
          slice_q <= slice_q + 2'd1;
          if (slice_q == 2'd3) begin
            cout_q <= sl_c[16];
            ovf_q  <= sl_c[16] ^ sl_c[15];
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign res_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Bench for add64_seq_ctrl: random and directed operations, a 64-bit
// arithmetic reference model and a scoreboard fed at each accepted request.
module tb_add64_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  add64_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .sub         (sub),
    .cin         (cin),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = -1;
  bit b2b = 1'b0;
  bit rv_prev = 1'b0;
  logic [65:0] exp_q[$];
  int          acc_q[$];

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain two's-complement arithmetic, result packed {ovf,cout,sum}.
  function automatic logic [65:0] model(input logic s, input logic ci,
                                        input logic [63:0] x, input logic [63:0] y);
    logic [64:0] full;
    logic [63:0] yy;
    logic        o;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {64'd0, (s ? 1'b1 : ci)};
    o    = (x[63] == yy[63]) && (full[63] != x[63]);
    return {o, full[64], full[63:0]};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (start_valid && start_ready) begin
        exp_q.push_back(model(sub, cin, a, b));
        acc_q.push_back(cyc);
        if (b2b && last_acc >= 0) chk("issue_interval", 66'(cyc - last_acc), 66'd6);
        last_acc = cyc;
      end
      if (res_valid && !rv_prev) begin
        if (acc_q.size() == 0) chk("unexpected_res_valid", 66'd1, 66'd0);
        else chk("result_latency", 66'(cyc - acc_q.pop_front()), 66'd5);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("result_without_request", 66'd1, 66'd0);
        else chk("result", {ovf, cout, sum}, exp_q.pop_front());
      end
      rv_prev = res_valid;
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    acc_q.delete();
    rv_prev = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    sub = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
  endtask

  // Present a request from a negedge; returns the number of cycles waited.
  task automatic issue(input logic s, input logic ci, input logic [63:0] x,
                       input logic [63:0] y, output int waited);
    sub = s; cin = ci; a = x; b = y;
    start_valid = 1'b1;
    waited = 0;
    while (!start_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!start_ready) chk("accept_timeout", 66'd1, 66'd0);
    @(negedge clk);
    start_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_res_valid();
    int n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) chk("res_valid_timeout", 66'd1, 66'd0);
  endtask

  task automatic take_result();
    wait_res_valid();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic s, input logic ci,
                          input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] e_sum, input logic e_cout,
                          input logic e_ovf);
    int w;
    issue(s, ci, x, y, w);
    wait_res_valid();
    chk({name, "_sum"}, {2'b00, sum}, {2'b00, e_sum});
    chk({name, "_cout"}, {65'd0, cout}, {65'd0, e_cout});
    chk({name, "_ovf"}, {65'd0, ovf}, {65'd0, e_ovf});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int quiet;
    #1;
    chk("rst_sum", {2'b00, sum}, 66'd0);
    chk("rst_cout_ovf", {64'd0, cout, ovf}, 66'd0);
    chk("rst_res_valid", {65'd0, res_valid}, 66'd0);
    chk("rst_busy", {65'd0, busy}, 66'd0);
    chk("rst_start_ready", {65'd0, start_ready}, 66'd1);

    // Release and request on the same negedge: accepted at the first edge.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, w);
    chk("first_accept_wait", 66'(w), 66'd0);
    take_result();

    directed("add_wrap", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    directed("add_ovf", 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    directed("sub_5_7", 1'b1, 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    directed("sub_7_5", 1'b1, 1'b0, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0);

    // Held result while new requests knock: nothing may change or start.
    for (int i = 0; i < 3; i++) begin
      scramble();
      start_valid = 1'b1;
      @(negedge clk);
      chk("hold_res_valid", {65'd0, res_valid}, 66'd1);
      chk("hold_sum", {2'b00, sum}, 66'd2);
      chk("hold_start_ready", {65'd0, start_ready}, 66'd0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;

    // Random operations with random consumer stalls.
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom}, w);
      wait_res_valid();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during slice 2 of an add aborts it.
    issue(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, w);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sum", {2'b00, sum}, 66'd0);
    chk("abort_flags", {61'd0, cout, ovf, res_valid, busy, start_ready}, 66'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    res_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) quiet++;
    end
    res_ready = 1'b0;
    chk("abort_no_res_valid", 66'(quiet), 66'd0);
    chk("abort_start_ready", {65'd0, start_ready}, 66'd1);

    // Back-to-back with both handshakes tied high.
    res_ready = 1'b1;
    last_acc = -1;
    b2b = 1'b1;
    start_valid = 1'b1;
    scramble();
    repeat (60) begin
      @(negedge clk);
      scramble();
    end
    start_valid = 1'b0;
    repeat (10) @(negedge clk);
    b2b = 1'b0;
    res_ready = 1'b0;

    chk("scoreboard_drained", 66'(exp_q.size()), 66'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add64_seq_ctrl.md
ADD64_SEQ_CTRL -- requirements
Module: add64_seq_ctrl

Interface
REQ-001 Parameters: none; slice width 16, slice count 4, operand width 64 are fixed.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start_valid  input  1  request to start an operation.
REQ-005 start_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 sub  input  1  0 = add, 1 = subtract (a - b).
REQ-007 cin  input  1  carry-in for add; ignored when sub=1.
REQ-008 a  input  64  operand A.
REQ-009 b  input  64  operand B.
REQ-010 res_valid  output  1  result available; held until accepted.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 sum  output  64  result word, registered.
REQ-013 cout  output  1  carry out of bit 63; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  signed overflow: carry into bit 63 XOR carry out of bit 63.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 The block SHALL contain one 16-bit slice adder (generate/propagate carry-lookahead, 4-bit groups) and SHALL reuse it over 4 cycles, low slice first.
REQ-017 The block SHALL use states IDLE, RUN, DONE; a 2-bit slice index; a 1-bit carry register.
REQ-018 Accept: at an edge with start_valid=1 and state IDLE, the block SHALL latch a, b (b inverted if sub=1), and the effective carry-in (sub ? 1 : cin), clear the slice index, and enter RUN.
REQ-019 Inputs a, b, sub, cin SHALL be sampled only at acceptance; later changes SHALL have no effect on the result.
REQ-020 RUN: at each edge, slice k (bits 16k+15:16k) SHALL be written to sum, the slice carry-out stored in the carry register, and k incremented.
REQ-021 At the edge writing slice 3, the block SHALL update cout and ovf, assert res_valid, and enter DONE; res_valid is therefore visible 4 cycles after acceptance.
REQ-022 DONE: res_valid, sum, cout, ovf SHALL remain stable until an edge with res_ready=1, then deassert res_valid and return to IDLE.
REQ-023 start_valid in RUN or DONE SHALL be ignored (start_ready=0); no request is queued.
REQ-024 res_ready while res_valid=0 SHALL have no effect.
REQ-025 sum, cout, ovf SHALL retain the last result in IDLE until the next operation overwrites them slice by slice.
REQ-026 Minimum issue interval SHALL be 6 cycles (accept, 4 RUN edges, DONE handshake edge, IDLE).

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, slice index 0, carry 0, sum 0, cout 0, ovf 0, res_valid 0, busy 0, start_ready 1.
REQ-028 Reset in RUN or DONE SHALL abort the operation; no res_valid SHALL appear for it.
REQ-029 The first acceptance SHALL be possible at the first rising edge after rst_n rises.

Verification
REQ-030 Add a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> after 4 cycles sum=0, cout=1, ovf=0.
REQ-031 Add a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-032 Subtract a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; subtract a=7, b=5 -> sum=2, cout=1.
REQ-033 Hold res_ready=0 for 3 cycles in DONE while driving start_valid=1 with new operands -> res_valid and sum stable, start_ready=0, no second operation starts.
REQ-034 Assert rst_n=0 during slice 2 of an add -> all outputs take reset values at once, no res_valid; start_ready=1 after release.
REQ-035 Back-to-back adds with start_valid and res_ready tied high -> exactly one acceptance every 6 cycles, each result matching a 64-bit reference model.
